stage_sequencer: RTL

Multi-cycle control FSM for the mriscv core. It walks each instruction through fetch, decode, execute, memory and writeback, and drives the stage enables into the fetch, decode, execute and register-file blocks. It owns the instruction- and data-memory request handshakes, bus timeouts, trap entry and the halt/resume protocol. It sits beside the datapath and consumes the decoder's classification flags (`is_load`, `is_store`, `is_branch`, `is_jump`).

---
 rtl/stage_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the mriscv core.
// Latency: 4 cycles per ALU/branch/jump op, 5 per load/store, plus one cycle per memory wait cycle.
// Backpressure: requests hold until ack or MEM_TIMEOUT; optional instret counter via STAGE_SEQUENCER_INSTRET_EN.
module stage_sequencer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        halt,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_branch,
   input  logic        is_jump,
   input  logic        illegal,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        fetch_en,
   output logic        decode_en,
   output logic        execute_en,
   output logic        reg_we,
   output logic        pc_we,
   output logic        retire,
   output logic        halted,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WB,
      S_HALTED,
      S_TRAP
   } state_t;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
   localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;
   // Counter value seen in the last allowed request cycle (counter starts at 0).
   localparam logic [7:0] TO_LAST       = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   state_t     state_nx;
   logic [1:0] cause_nx;
   logic [7:0] to_cnt;
   logic       to_hit;
   logic       ld_q;
   logic       st_q;
   logic       nowb_q;
   logic       entering_req;

   // Jumps sequence exactly like ALU ops (write back, no memory phase).
   logic       unused_flags;
   assign unused_flags = is_jump;

   assign to_hit   = (to_cnt == TO_LAST);
   assign fetch_en = imem_req & imem_ack;

   always_comb begin
      state_nx = state;
      cause_nx = trap_cause;
      unique case (state)
         S_IDLE:    state_nx = halt ? S_HALTED : S_FETCH;
         S_FETCH: begin
            if (imem_ack) begin
               state_nx = S_DECODE;
            end else if (to_hit) begin
               state_nx = S_TRAP;
               cause_nx = CAUSE_IMEM_TO;
            end
         end
         S_DECODE: begin
            if (illegal) begin
               state_nx = S_TRAP;
               cause_nx = CAUSE_ILLEGAL;
            end else begin
               state_nx = S_EXECUTE;
            end
         end
         S_EXECUTE: state_nx = (ld_q | st_q) ? S_MEM : S_WB;
         S_MEM: begin
            if (dmem_ack) begin
               state_nx = S_WB;
            end else if (to_hit) begin
               state_nx = S_TRAP;
               cause_nx = CAUSE_DMEM_TO;
            end
         end
         S_WB:      state_nx = halt ? S_HALTED : S_FETCH;
         S_HALTED:  state_nx = halt ? S_HALTED : S_FETCH;
         S_TRAP:    state_nx = S_TRAP;
      endcase
   end

   assign entering_req = ((state_nx == S_FETCH) && (state != S_FETCH)) ||
                         ((state_nx == S_MEM)   && (state != S_MEM));

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         trap_cause <= 2'b00;
         to_cnt     <= 8'd0;
         ld_q       <= 1'b0;
         st_q       <= 1'b0;
         nowb_q     <= 1'b0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         decode_en  <= 1'b0;
         execute_en <= 1'b0;
         reg_we     <= 1'b0;
         pc_we      <= 1'b0;
         retire     <= 1'b0;
         halted     <= 1'b0;
         trap       <= 1'b0;
      end else begin
         state      <= state_nx;
         trap_cause <= cause_nx;

         if (state == S_DECODE && !illegal) begin
            ld_q   <= is_load;
            st_q   <= is_store;
            nowb_q <= is_store | is_branch;
         end

         if (entering_req) begin
            to_cnt <= 8'd0;
         end else if ((state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack)) begin
            to_cnt <= to_cnt + 8'd1;
         end

         imem_req   <= (state_nx == S_FETCH);
         dmem_req   <= (state_nx == S_MEM);
         dmem_we    <= (state_nx == S_MEM) && st_q;
         decode_en  <= (state_nx == S_DECODE);
         execute_en <= (state_nx == S_EXECUTE);
         reg_we     <= (state_nx == S_WB) && !nowb_q;
         pc_we      <= (state_nx == S_WB);
         retire     <= (state_nx == S_WB);
         halted     <= (state_nx == S_HALTED);
         trap       <= (state_nx == S_TRAP);
      end
   end

`ifdef STAGE_SEQUENCER_INSTRET_EN
   logic [31:0] instret_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_q <= 32'd0;
      end else if (retire) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   assign instret = instret_q;
`else
   assign instret = 32'd0;
`endif

endmodule
